// File: rtl/knn_pkg.sv
// Shared definitions for the KNN sample streamer: FSM encoding and sample-name width.
package knn_pkg;

  localparam int unsigned NameWidth = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StFin
  } streamState_e;

endpackage

// File: rtl/knn_sample_slot.sv
// One ping-pong slot: a whole sample of dimension values, its name and a full flag.
module knn_sample_slot
  import knn_pkg::*;
#(
  parameter int unsigned dataWidth          = 32,
  parameter int unsigned numberOfDimensions = 32,
  localparam int unsigned DimW              = $clog2(numberOfDimensions)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wrEn_i,
  input  logic [DimW-1:0]      wrDim_i,
  input  logic [dataWidth-1:0] wrData_i,
  input  logic [NameWidth-1:0] wrName_i,
  input  logic                 release_i,
  input  logic [DimW-1:0]      rdDim_i,
  output logic [dataWidth-1:0] rdData_o,
  output logic [NameWidth-1:0] name_o,
  output logic                 full_o
);

  localparam logic [DimW-1:0] LastDim = DimW'(numberOfDimensions - 1);

  logic [dataWidth-1:0] mem [numberOfDimensions];
  logic [NameWidth-1:0] nameQ;
  logic                 fullQ;

  // Payload storage carries no reset; only the full flag matters after reset.
  always_ff @(posedge clk) begin
    if (wrEn_i) begin
      mem[wrDim_i] <= wrData_i;
      if (wrDim_i == '0) begin
        nameQ <= wrName_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fullQ <= 1'b0;
    end else if (release_i) begin
      fullQ <= 1'b0;
    end else if (wrEn_i && (wrDim_i == LastDim)) begin
      fullQ <= 1'b1;
    end
  end

  assign rdData_o = mem[rdDim_i];
  assign name_o   = nameQ;
  assign full_o   = fullQ;

endmodule

// File: rtl/knn_sample_streamer.sv
// Streams host samples through two ping-pong slots as unbroken per-sample bursts.
// Define KNN_STREAMER_STATS_EN to enable the completed-burst counter on samplesOut.
module knn_sample_streamer
  import knn_pkg::*;
#(
  parameter int unsigned dataWidth          = 32,
  parameter int unsigned numberOfDimensions = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          numSamples,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [NameWidth-1:0] inName,
  input  logic [dataWidth-1:0] inData,
  output logic                 outValid,
  output logic [NameWidth-1:0] dataNameOut,
  output logic [dataWidth-1:0] dataValueOut,
  output logic                 done,
  output logic                 busy,
  output logic [31:0]          samplesOut
);

  localparam int unsigned DimW = $clog2(numberOfDimensions);
  localparam logic [DimW-1:0] LastDim = DimW'(numberOfDimensions - 1);

  streamState_e         state;
  logic [31:0]          numSamplesQ;
  logic [31:0]          acceptedCnt;
  logic [DimW-1:0]      wrDim;
  logic [DimW-1:0]      rdDim;
  logic                 wrSlot;
  logic                 rdSlot;
  logic [1:0]           slotFull;
  logic [1:0]           slotWrEn;
  logic [1:0]           slotRelease;
  logic [dataWidth-1:0] slotData [2];
  logic [NameWidth-1:0] slotName [2];
  logic                 accept;
  logic                 lastWord;
  logic                 lastBeat;

  assign inReady  = (state == StRun) && !slotFull[wrSlot] && (acceptedCnt < numSamplesQ);
  assign accept   = inValid && inReady;
  assign lastWord = accept && (wrDim == LastDim);

  // Slots are read in fill order, so the read slot being full is exactly "a burst is active".
  assign outValid     = slotFull[rdSlot];
  assign lastBeat     = outValid && (rdDim == LastDim);
  assign dataValueOut = outValid ? slotData[rdSlot] : '0;
  assign dataNameOut  = outValid ? slotName[rdSlot] : '0;
  assign done         = (state == StFin);
  assign busy         = (state != StIdle);

  always_comb begin
    slotWrEn            = '0;
    slotRelease         = '0;
    slotWrEn[wrSlot]    = accept;
    slotRelease[rdSlot] = lastBeat;
  end

  knn_sample_slot #(
    .dataWidth         (dataWidth),
    .numberOfDimensions(numberOfDimensions)
  ) uSlot0 (
    .clk      (clk),
    .reset    (reset),
    .wrEn_i   (slotWrEn[0]),
    .wrDim_i  (wrDim),
    .wrData_i (inData),
    .wrName_i (inName),
    .release_i(slotRelease[0]),
    .rdDim_i  (rdDim),
    .rdData_o (slotData[0]),
    .name_o   (slotName[0]),
    .full_o   (slotFull[0])
  );

  knn_sample_slot #(
    .dataWidth         (dataWidth),
    .numberOfDimensions(numberOfDimensions)
  ) uSlot1 (
    .clk      (clk),
    .reset    (reset),
    .wrEn_i   (slotWrEn[1]),
    .wrDim_i  (wrDim),
    .wrData_i (inData),
    .wrName_i (inName),
    .release_i(slotRelease[1]),
    .rdDim_i  (rdDim),
    .rdData_o (slotData[1]),
    .name_o   (slotName[1]),
    .full_o   (slotFull[1])
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StIdle;
      numSamplesQ <= '0;
      acceptedCnt <= '0;
      wrDim       <= '0;
      rdDim       <= '0;
      wrSlot      <= 1'b0;
      rdSlot      <= 1'b0;
    end else begin
      if (accept) begin
        if (lastWord) begin
          wrDim       <= '0;
          wrSlot      <= ~wrSlot;
          acceptedCnt <= acceptedCnt + 32'd1;
        end else begin
          wrDim <= wrDim + 1'b1;
        end
      end
      if (outValid) begin
        if (lastBeat) begin
          rdDim  <= '0;
          rdSlot <= ~rdSlot;
        end else begin
          rdDim <= rdDim + 1'b1;
        end
      end
      unique case (state)
        StIdle: begin
          if (start) begin
            numSamplesQ <= numSamples;
            acceptedCnt <= '0;
            state       <= (numSamples == '0) ? StFin : StRun;
          end
        end
        StRun: begin
          if (lastWord && (acceptedCnt == numSamplesQ - 32'd1)) begin
            state <= StDrain;
          end
        end
        StDrain: begin
          // No more writes here, so the run ends once the other slot is also empty.
          if (lastBeat && !slotFull[~rdSlot]) begin
            state <= StFin;
          end
        end
        StFin:   state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

`ifdef KNN_STREAMER_STATS_EN
  logic [31:0] burstCnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      burstCnt <= '0;
    end else if ((state == StIdle) && start) begin
      burstCnt <= '0;
    end else if (lastBeat) begin
      burstCnt <= burstCnt + 32'd1;
    end
  end

  assign samplesOut = burstCnt;
`else
  assign samplesOut = '0;
`endif

endmodule

// File: tb/tb_knn_sample_streamer.sv
// Directed bench for knn_sample_streamer with 4 dimensions of 32 bits.
module tb_knn_sample_streamer;

  localparam int unsigned Dw = 32;
  localparam int Nd = 4;
`ifdef KNN_STREAMER_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   numSamples;
  logic          inValid;
  logic          inReady;
  logic [31:0]   inName;
  logic [Dw-1:0] inData;
  logic          outValid;
  logic [31:0]   dataNameOut;
  logic [Dw-1:0] dataValueOut;
  logic          done;
  logic          busy;
  logic [31:0]   samplesOut;

  always #5 clk = ~clk;

  knn_sample_streamer #(
    .dataWidth         (Dw),
    .numberOfDimensions(Nd)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .numSamples  (numSamples),
    .inValid     (inValid),
    .inReady     (inReady),
    .inName      (inName),
    .inData      (inData),
    .outValid    (outValid),
    .dataNameOut (dataNameOut),
    .dataValueOut(dataValueOut),
    .done        (done),
    .busy        (busy),
    .samplesOut  (samplesOut)
  );

  typedef struct {
    int n;
    bit stall;
    int base;
    int nameBase;
    bit repulse;
    int expBeats;
    int expSamples;
  } vec_t;

  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  int   startCyc;

  int beatVal[$];
  int beatName[$];
  int beatCyc[$];
  int sampleCyc[$];
  int doneCnt;
  int doneCyc;
  int accWords;
  int curN;
  bit idleDirty;
  bit readyBad;

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (outValid === 1'b1) begin
      beatVal.push_back(int'(dataValueOut));
      beatName.push_back(int'(dataNameOut));
      beatCyc.push_back(cycle);
    end else if (dataValueOut !== '0 || dataNameOut !== '0) begin
      idleDirty = 1'b1;
    end
    if (done === 1'b1) begin
      doneCnt++;
      doneCyc = cycle;
    end
    // Samples held but not fully emitted; two means both slots are occupied.
    if (inReady === 1'b1 && (busy !== 1'b1 || accWords / Nd >= curN ||
        accWords / Nd - beatVal.size() / Nd >= 2)) begin
      readyBad = 1'b1;
    end
    if (inValid === 1'b1 && inReady === 1'b1) begin
      if (accWords % Nd == Nd - 1) sampleCyc.push_back(cycle);
      accWords++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clearMon();
    beatVal.delete();
    beatName.delete();
    beatCyc.delete();
    sampleCyc.delete();
    doneCnt   = 0;
    doneCyc   = -1;
    accWords  = 0;
    idleDirty = 1'b0;
    readyBad  = 1'b0;
  endtask

  task automatic sendRun(input vec_t v);
    int guard;
    clearMon();
    curN       = v.n;
    numSamples = v.n;
    start      = 1'b1;
    startCyc   = cycle;
    tick();
    start = 1'b0;
    for (int s = 0; s < v.n; s++) begin
      for (int d = 0; d < Nd; d++) begin
        if (v.stall && d == 2) begin
          inValid = 1'b0;
          tick();
        end
        if (v.repulse && s == 1 && d == 0) begin
          start      = 1'b1;
          numSamples = 99;
        end
        inValid = 1'b1;
        inName  = (d == 0) ? v.nameBase + s : 32'hFFFF;
        inData  = v.base + s * Nd + d;
        guard   = 0;
        while (!inReady && guard < 50) begin
          tick();
          guard++;
        end
        if (guard == 50) check("inReady wait", inReady, 1'b1);
        tick();
        start = 1'b0;
      end
    end
    inValid = 1'b0;
    guard   = 0;
    while (doneCnt == 0 && guard < 200) begin
      tick();
      guard++;
    end
    if (guard == 200) check("done timeout", done, 1'b1);
    tick();
    tick();
  endtask

  task automatic verifyRun(input vec_t v, input int idx);
    int last;
    check($sformatf("v%0d beat count", idx), beatVal.size(), v.expBeats);
    for (int k = 0; k < beatVal.size() && k < v.expBeats; k++) begin
      check($sformatf("v%0d beat%0d value", idx, k), beatVal[k], v.base + k);
      check($sformatf("v%0d beat%0d name", idx, k), beatName[k], v.nameBase + k / Nd);
      if (k % Nd != 0) begin
        check($sformatf("v%0d beat%0d contiguous", idx, k), beatCyc[k] - beatCyc[k - 1], 1);
      end
    end
    check($sformatf("v%0d done pulses", idx), doneCnt, 1);
    if (v.expBeats == 0) begin
      check($sformatf("v%0d done after start", idx), doneCyc - startCyc, 1);
    end else if (beatVal.size() > 0) begin
      last = beatCyc.size() - 1;
      check($sformatf("v%0d done after last beat", idx), doneCyc - beatCyc[last], 1);
      if (sampleCyc.size() > 0) begin
        check($sformatf("v%0d first burst latency", idx), beatCyc[0] - sampleCyc[0], 1);
      end
      if (!v.stall) begin
        check($sformatf("v%0d stream unbroken", idx), beatCyc[last] - beatCyc[0],
              v.expBeats - 1);
      end
    end
    check($sformatf("v%0d zero when idle", idx), idleDirty, 1'b0);
    check($sformatf("v%0d inReady gating", idx), readyBad, 1'b0);
    check($sformatf("v%0d busy after done", idx), busy, 1'b0);
    check($sformatf("v%0d samplesOut", idx), samplesOut, StatsOn ? v.expSamples : 0);
  endtask

  initial begin
    int   guard;
    vec_t fresh;
    vecs[0] = '{n: 1, stall: 0, base: 10,  nameBase: 7,  repulse: 0, expBeats: 4,  expSamples: 1};
    vecs[1] = '{n: 3, stall: 0, base: 100, nameBase: 20, repulse: 0, expBeats: 12, expSamples: 3};
    vecs[2] = '{n: 2, stall: 1, base: 200, nameBase: 30, repulse: 0, expBeats: 8,  expSamples: 2};
    vecs[3] = '{n: 0, stall: 0, base: 0,   nameBase: 0,  repulse: 0, expBeats: 0,  expSamples: 0};
    vecs[4] = '{n: 2, stall: 0, base: 300, nameBase: 40, repulse: 1, expBeats: 8,  expSamples: 2};
    fresh   = '{n: 1, stall: 0, base: 900, nameBase: 77, repulse: 0, expBeats: 4,  expSamples: 1};

    reset      = 1'b1;
    start      = 1'b0;
    numSamples = '0;
    inValid    = 1'b0;
    inName     = '0;
    inData     = '0;
    curN       = 0;
    clearMon();
    tick();
    tick();
    tick();
    reset = 1'b0;
    check("reset outValid", outValid, 1'b0);
    check("reset done", done, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset inReady", inReady, 1'b0);
    check("reset dataValueOut", dataValueOut, 32'd0);
    check("reset dataNameOut", dataNameOut, 32'd0);
    check("reset samplesOut", samplesOut, 32'd0);

    for (int i = 0; i < 5; i++) begin
      sendRun(vecs[i]);
      verifyRun(vecs[i], i);
    end

    // Abort a 3-sample run on the second beat of its first burst.
    clearMon();
    curN       = 3;
    numSamples = 3;
    start      = 1'b1;
    tick();
    start   = 1'b0;
    inValid = 1'b1;
    inName  = 60;
    inData  = 500;
    guard   = 0;
    while (!(outValid && beatVal.size() == 1) && guard < 40) begin
      tick();
      inData = inData + 1;
      guard++;
    end
    check("abort reached beat 2", beatVal.size(), 1);
    check("abort beat 2 valid", outValid, 1'b1);
    reset   = 1'b1;
    inValid = 1'b0;
    tick();
    reset = 1'b0;
    check("abort outValid", outValid, 1'b0);
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort inReady", inReady, 1'b0);
    check("abort dataValueOut", dataValueOut, 32'd0);
    check("abort dataNameOut", dataNameOut, 32'd0);
    check("abort samplesOut", samplesOut, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    check("abort no done", doneCnt, 0);
    check("abort no more beats", beatVal.size(), 2);

    sendRun(fresh);
    verifyRun(fresh, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/knn_sample_streamer.md
KNN_SAMPLE_STREAMER -- requirements
Module: knn_sample_streamer

Interface
REQ-001 SHALL have parameter dataWidth, default 32: width of one dimension value.
REQ-002 SHALL have parameter numberOfDimensions, default 32: values per sample, at least 2.
REQ-003 SHALL have one clock, clk; reset is synchronous and active-high, named reset.
REQ-004 Ports:
- clk  in  1  clock.
- reset  in  1  sync active-high reset.
- start  in  1  one-cycle pulse that begins a query run.
- numSamples  in  32  samples in the run, sampled on start.
- inValid  in  1  host word valid.
- inReady  out  1  host word accepted when inValid && inReady.
- inName  in  32  sample ID, meaningful on dimension-0 word.
- inData  in  dataWidth  one dimension value, dimension 0 first.
- outValid  out  1  burst beat valid.
- dataNameOut  out  32  ID of the sample in the burst.
- dataValueOut  out  dataWidth  dimension value of the beat.
- done  out  1  one-cycle end-of-run pulse, feeds the downstream sorter's done.
- busy  out  1  run in progress.
- samplesOut  out  32  bursts emitted this run.

Function
REQ-005 SHALL accept samples from the host and emit each one as an unbroken burst of numberOfDimensions consecutive outValid beats, dimension 0 first, aligned with the downstream reference FIFO.
REQ-006 SHALL buffer whole samples in two ping-pong slots, each numberOfDimensions x dataWidth plus a 32-bit name.
REQ-007 SHALL capture inName on the dimension-0 word; dataNameOut SHALL hold that name for all beats of the burst.
REQ-008 SHALL use FSM states IDLE, RUN, DRAIN and FIN.
- IDLE->RUN on start when numSamples>0.
- IDLE->FIN on start when numSamples==0.
- RUN->DRAIN when the last word of sample numSamples is accepted.
- DRAIN->FIN when the final burst beat has been emitted.
- FIN->IDLE after one cycle.
REQ-009 busy SHALL be high in RUN, DRAIN and FIN.
REQ-010 done SHALL be high only in FIN.
REQ-011 A start pulse while busy SHALL be ignored.
REQ-012 inReady SHALL be high only in RUN, when a slot is not full and accepted samples < numSamples.
REQ-013 A burst SHALL begin the cycle after the slot's last word is accepted, if no burst is active.
REQ-014 If a burst is active, the next burst SHALL begin the cycle after it ends, with zero gap.
REQ-015 A slot SHALL become writable the cycle after its last beat.
REQ-016 When one slot fills in the same cycle the other drains its last beat, the bursts SHALL be back-to-back with no lost or duplicated beat.
REQ-017 Host stalls (inValid low) mid-sample SHALL be absorbed; outValid SHALL never drop mid-burst.
REQ-018 The dimension counter SHALL wrap from numberOfDimensions-1 to 0.
REQ-019 The sample counter SHALL be 32 bits; wrap is not supported.
REQ-020 done SHALL assert the cycle after the final beat.
REQ-021 For numSamples==0, done SHALL assert the cycle after start, with no beats.
REQ-022 dataValueOut and dataNameOut SHALL read 0 when outValid is low.

Reset
REQ-023 On reset, all outputs SHALL be 0 and FSM=IDLE.
REQ-024 On reset, all counters and slot-full flags SHALL clear; buffer contents need not clear.
REQ-025 Reset mid-run SHALL abort the run: no done, the partial burst truncated, the next cycle IDLE.

Configuration
REQ-026 With macro KNN_STREAMER_STATS_EN defined, samplesOut SHALL count completed bursts, clear on start, and hold after done until the next start.
REQ-027 Without KNN_STREAMER_STATS_EN, samplesOut SHALL be tied to 0 and the counter SHALL be absent.

Structure
REQ-028 Shared package knn_pkg SHALL hold the FSM state encoding and the 32-bit name-width constant.
REQ-029 One sub-module, knn_sample_slot (a single ping-pong slot: storage, name register, full flag), SHALL be instantiated twice.

Verification (numberOfDimensions=4, dataWidth=32)
REQ-030 Start with numSamples=1, then words 10,11,12,13 with inName=7 -> outValid for 4 cycles with values 10..13, dataNameOut=7 throughout, done the cycle after, samplesOut=1.
REQ-031 numSamples=3, host streams continuously -> 12 contiguous beats with names changing every 4 beats, one done pulse, inReady low while both slots are full.
REQ-032 numSamples=2, inValid toggled 1/0 mid-sample -> each burst is still 4 contiguous beats with correct values.
REQ-033 numSamples=0 -> done one cycle after start, outValid never high.
REQ-034 Reset asserted on the second beat of the first burst of a 3-sample run -> outputs 0 the next cycle, no done, and a fresh 1-sample run afterwards succeeds.
REQ-035 start re-pulsed during RUN -> ignored; beat count and done timing unchanged.
